// File: rtl/tdc_carry_chain_encoder.sv
`timescale 1ps/1ps
// tdc_carry_chain_encoder
// Single-channel carry-chain TDC. NUM_CARRY4 cascaded CARRY4 stages form a
// tapped delay line on the hit input. The taps are double-sampled on clk,
// encoded from thermometer code to binary fine time, and stamped with a
// free-running coarse count. An arm/dead-time FSM suppresses retriggering.
// Optional macro TDC_BUBBLE_FILTER_EN adds a registered majority-of-3 bubble
// filter on the sampled taps, which costs one extra cycle of latency.
//
// state | meaning
// IDLE  | hits ignored, armed=0
// ARMED | waiting for tap 0 to be seen high
// DEAD  | post-capture hold-off; waits for the down-counter and for hit release
module tdc_carry_chain_encoder #(
    parameter  int NUM_CARRY4 = 8,
    parameter  int COARSE_W   = 16,
    parameter  int DEAD_CYC   = 4,
    parameter  int SIM_TAP_PS = 100,
    localparam int NTAPS      = 4 * NUM_CARRY4,
    localparam int FINE_W     = $clog2(NTAPS + 1)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                hit,
    input  logic                arm,
    output logic                ts_valid,
    output logic [FINE_W-1:0]   ts_fine,
    output logic [COARSE_W-1:0] ts_coarse,
    output logic                ts_sat,
    output logic                armed
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        DEAD  = 2'd2
    } state_t;

    localparam logic [7:0] DEAD_LOAD = 8'(DEAD_CYC);

    logic [NTAPS-1:0]    tap;
    logic [NTAPS-1:0]    tap_q1;
    logic [NTAPS-1:0]    tap_q2;
    logic [COARSE_W-1:0] cnt;
    logic [COARSE_W-1:0] coarse_q1;
    logic [COARSE_W-1:0] coarse_q2;
    logic [NTAPS-1:0]    enc_src;
    logic [COARSE_W-1:0] enc_coarse;
    logic [FINE_W-1:0]   enc_fine;
    logic                enc_sat;
    logic                capture;
    state_t              state;
    state_t              state_nx;
    logic [7:0]          dead_cnt;
    logic [7:0]          dead_nx;

`ifdef SYNTHESIS
    // Delay line built from real CARRY4 primitives; each stage propagates
    // the hit through its four carry muxes.
    for (genvar k = 0; k < NUM_CARRY4; k++) begin : g_c4
        logic ci;
        if (k == 0) begin : g_first
            assign ci = hit;
        end else begin : g_next
            assign ci = tap[4*k-1];
        end
        CARRY4 u_carry4 (
            .CO     (tap[4*k +: 4]),
            .O      (),
            .CI     (ci),
            .CYINIT (1'b0),
            .DI     (4'b0000),
            .S      (4'b1111)
        );
    end
`else
    // Behavioural chain: every hit edge reappears at tap i after (i+1) tap
    // delays; the delayed non-blocking form keeps transport semantics.
    for (genvar i = 0; i < NTAPS; i++) begin : g_tap
        logic tap_d;
        always @(hit) tap_d <= #((i + 1) * SIM_TAP_PS) hit;
        assign tap[i] = tap_d;
    end
`endif

    // Two-stage tap sampling and the coarse count pipelined alongside it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tap_q1    <= '0;
            tap_q2    <= '0;
            cnt       <= '0;
            coarse_q1 <= '0;
            coarse_q2 <= '0;
        end else begin
            tap_q1    <= tap;
            tap_q2    <= tap_q1;
            cnt       <= cnt + COARSE_W'(1);
            coarse_q1 <= cnt;
            coarse_q2 <= coarse_q1;
        end
    end

`ifdef TDC_BUBBLE_FILTER_EN
    logic [NTAPS+1:0]    tap_pad;
    logic [NTAPS-1:0]    tap_maj;
    logic [NTAPS-1:0]    tap_f;
    logic [COARSE_W-1:0] coarse_q3;

    // Below tap 0 the line is treated as already filled, above the top as empty.
    assign tap_pad = {1'b0, tap_q2, 1'b1};

    // Majority of each tap and its two neighbours removes single bubbles.
    always_comb begin
        tap_maj = '0;
        for (int i = 0; i < NTAPS; i++) begin
            tap_maj[i] = (tap_pad[i] & tap_pad[i+1]) |
                         (tap_pad[i] & tap_pad[i+2]) |
                         (tap_pad[i+1] & tap_pad[i+2]);
        end
    end

    // Filtered taps and the matching coarse stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tap_f     <= '0;
            coarse_q3 <= '0;
        end else begin
            tap_f     <= tap_maj;
            coarse_q3 <= coarse_q2;
        end
    end

    assign enc_src    = tap_f;
    assign enc_coarse = coarse_q3;
`else
    assign enc_src    = tap_q2;
    assign enc_coarse = coarse_q2;
`endif

    // Fine time is the index of the first 0; an all-ones line saturates.
    always_comb begin
        enc_fine = FINE_W'(NTAPS);
        enc_sat  = 1'b1;
        for (int i = NTAPS - 1; i >= 0; i--) begin
            if (!enc_src[i]) begin
                enc_fine = FINE_W'(i);
                enc_sat  = 1'b0;
            end
        end
    end

    assign capture = (state == ARMED) && enc_src[0];
    assign armed   = (state == ARMED);

    // Timestamp register; fields hold until the next capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ts_valid  <= 1'b0;
            ts_fine   <= '0;
            ts_coarse <= '0;
            ts_sat    <= 1'b0;
        end else begin
            ts_valid <= capture;
            if (capture) begin
                ts_fine   <= enc_fine;
                ts_coarse <= enc_coarse;
                ts_sat    <= enc_sat;
            end
        end
    end

    // FSM state and dead-time down-counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            dead_cnt <= '0;
        end else begin
            state    <= state_nx;
            dead_cnt <= dead_nx;
        end
    end

    // Next-state: a capture beats a falling arm; DEAD exits only after the
    // counter expires and the hit has been seen released.
    always_comb begin
        state_nx = state;
        dead_nx  = dead_cnt;
        case (state)
            IDLE: begin
                if (arm) state_nx = ARMED;
            end
            ARMED: begin
                if (capture) begin
                    state_nx = DEAD;
                    dead_nx  = DEAD_LOAD;
                end else if (!arm) begin
                    state_nx = IDLE;
                end
            end
            DEAD: begin
                if (dead_cnt == 8'd0 && !enc_src[0]) begin
                    state_nx = arm ? ARMED : IDLE;
                end else if (dead_cnt != 8'd0) begin
                    dead_nx = dead_cnt - 8'd1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

endmodule

// File: tb/tb_tdc_carry_chain_encoder.sv
`timescale 1ps/1ps
// Self-checking bench: the reference model reconstructs every tap from the
// recorded hit waveform (tap i = hit level (i+1) tap delays before the edge)
// and pushes expected timestamps into a queue; a negedge monitor pops them.
// All hit/arm/reset changes land 50 ps off the 100 ps grid, so no tap ever
// switches exactly on a sampling edge.
module tb_tdc_carry_chain_encoder;

    localparam int NUM_CARRY4 = 8;
    localparam int NTAPS      = 4 * NUM_CARRY4;
    localparam int COARSE_W   = 4;
    localparam int DEAD_CYC   = 4;
    localparam int TAP_PS     = 100;
    localparam int FINE_W     = $clog2(NTAPS + 1);
    localparam int HALF       = 5000;
    localparam int PERIOD     = 10000;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                hit = 1'b0;
    logic                arm = 1'b0;
    logic                ts_valid;
    logic [FINE_W-1:0]   ts_fine;
    logic [COARSE_W-1:0] ts_coarse;
    logic                ts_sat;
    logic                armed;

    tdc_carry_chain_encoder #(
        .NUM_CARRY4 (NUM_CARRY4),
        .COARSE_W   (COARSE_W),
        .DEAD_CYC   (DEAD_CYC),
        .SIM_TAP_PS (TAP_PS)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .hit       (hit),
        .arm       (arm),
        .ts_valid  (ts_valid),
        .ts_fine   (ts_fine),
        .ts_coarse (ts_coarse),
        .ts_sat    (ts_sat),
        .armed     (armed)
    );

    initial forever #(HALF) clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(string name, longint act, longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- hit waveform record ----------------
    typedef struct {longint t; bit v;} hev_t;
    hev_t hist[$];

    task automatic set_hit(bit v);
        hev_t e;
        hit = v;
        e.t = longint'($time);
        e.v = v;
        hist.push_back(e);
        if (hist.size() > 64) void'(hist.pop_front());
    endtask

    function automatic bit hit_at(longint t);
        bit v = 1'b0;
        foreach (hist[i]) if (hist[i].t < t) v = hist[i].v;
        return v;
    endfunction

    function automatic logic [NTAPS-1:0] sample_taps(longint t);
        logic [NTAPS-1:0] v;
        for (int i = 0; i < NTAPS; i++) v[i] = hit_at(t - longint'((i + 1) * TAP_PS));
        return v;
    endfunction

    function automatic int first_zero(logic [NTAPS-1:0] v);
        for (int i = 0; i < NTAPS; i++) if (!v[i]) return i;
        return NTAPS;
    endfunction

    function automatic logic [NTAPS-1:0] majority(logic [NTAPS-1:0] v);
        logic [NTAPS-1:0] f;
        for (int i = 0; i < NTAPS; i++) begin
            int ones;
            ones = int'(v[i]) + ((i == 0) ? 1 : int'(v[i-1])) + ((i == NTAPS - 1) ? 0 : int'(v[i+1]));
            f[i] = (ones >= 2);
        end
        return f;
    endfunction

    // ---------------- reference model ----------------
    typedef enum {M_IDLE, M_ARMED, M_DEAD} mst_t;
    typedef struct {int fine; int coarse; bit sat; longint cyc;} exp_t;

    exp_t             expq[$];
    mst_t             m_st = M_IDLE;
    int               m_dead = 0;
    logic [NTAPS-1:0] m_q1 = '0, m_q2 = '0, m_f = '0;
    int               m_cnt = 0, m_c1 = 0, m_c2 = 0, m_c3 = 0;
    longint           edge_n = 0;

    always @(posedge clk) begin : model
        logic [NTAPS-1:0] src;
        int               csrc;
        exp_t             e;
        edge_n++;
        if (!rst_n) begin
            m_st = M_IDLE; m_dead = 0;
            m_q1 = '0; m_q2 = '0; m_f = '0;
            m_cnt = 0; m_c1 = 0; m_c2 = 0; m_c3 = 0;
            expq.delete();
        end else begin
`ifdef TDC_BUBBLE_FILTER_EN
            src = m_f; csrc = m_c3;
`else
            src = m_q2; csrc = m_c2;
`endif
            case (m_st)
                M_IDLE: if (arm) m_st = M_ARMED;
                M_ARMED: begin
                    if (src[0]) begin
                        e.fine = first_zero(src);
                        e.coarse = csrc;
                        e.sat = (e.fine == NTAPS);
                        e.cyc = edge_n;
                        expq.push_back(e);
                        m_st = M_DEAD;
                        m_dead = DEAD_CYC;
                    end else if (!arm) m_st = M_IDLE;
                end
                default: begin
                    if (m_dead == 0 && !src[0]) m_st = arm ? M_ARMED : M_IDLE;
                    else if (m_dead > 0) m_dead--;
                end
            endcase
`ifdef TDC_BUBBLE_FILTER_EN
            m_f = majority(m_q2); m_c3 = m_c2;
`endif
            m_q2 = m_q1; m_c2 = m_c1;
            m_q1 = sample_taps(longint'($time)); m_c1 = m_cnt;
            m_cnt = (m_cnt + 1) % (1 << COARSE_W);
        end
    end

    // ---------------- monitor ----------------
    exp_t   hold = '{0, 0, 1'b0, 0};
    int     n_valid = 0;
    int     last_fine = 0;
    int     last_sat = 0;
    longint last_cyc = 0, prev_cyc = 0;

    always @(negedge clk) begin : monitor
        exp_t e;
        bit   pending;
        if (!rst_n) begin
            hold = '{0, 0, 1'b0, 0};
            check("reset_outputs", {ts_valid, ts_fine, ts_coarse, ts_sat, armed}, 0);
        end else begin
            check("armed", armed, m_st == M_ARMED);
            if (ts_valid) begin
                n_valid++;
                last_fine = ts_fine;
                last_sat = ts_sat;
                prev_cyc = last_cyc;
                last_cyc = edge_n;
                check("valid_has_expect", expq.size() > 0, 1);
                if (expq.size() > 0) begin
                    e = expq.pop_front();
                    check("ts_cycle", edge_n, e.cyc);
                    check("ts_fine", ts_fine, e.fine);
                    check("ts_coarse", ts_coarse, e.coarse);
                    check("ts_sat", ts_sat, e.sat);
                    hold = e;
                end
            end else begin
                pending = (expq.size() > 0) && (expq[0].cyc <= edge_n);
                check("valid_missing", pending, 0);
                if (pending) void'(expq.pop_front());
                check("hold_fine", ts_fine, hold.fine);
                check("hold_coarse", ts_coarse, hold.coarse);
                check("hold_sat", ts_sat, hold.sat);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc(int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic at_off(int ps);
        @(posedge clk);
        #(ps);
    endtask

    task automatic finish_run();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    endtask

    initial begin
        #(longint'(PERIOD) * 20000);
        n_bad++;
        $display("FAIL watchdog: stimulus did not complete in time");
        finish_run();
    end

    initial begin
        int v0;
        set_hit(1'b0);
        // reset with a hit pulse inside it, then idle with arm=0
        at_off(2050); set_hit(1'b1);
        at_off(2050); set_hit(1'b0);
        at_off(6050); rst_n = 1'b1;
        at_off(3050); set_hit(1'b1);
        cyc(3);
        at_off(3050); set_hit(1'b0);
        cyc(4);
        check("idle_no_valid", n_valid, 0);

        // basic capture: hit 1050 ps before the edge -> 10 taps
        at_off(6050); arm = 1'b1;
        cyc(4);
        at_off(PERIOD - 1050); set_hit(1'b1);
        cyc(4);
        at_off(5050); set_hit(1'b0);
        cyc(10);
        check("basic_count", n_valid, 1);
        check("basic_fine", last_fine, 10);
        check("basic_sat", last_sat, 0);

        // saturation: 5050 ps covers the whole 3.2 ns line
        at_off(PERIOD - 5050); set_hit(1'b1);
        cyc(4);
        at_off(5050); set_hit(1'b0);
        cyc(10);
        check("sat_count", n_valid, 2);
        check("sat_fine", last_fine, NTAPS);
        check("sat_flag", last_sat, 1);

        // hit held 20 cycles: one event; then low one cycle and high again
        at_off(PERIOD - 2050); set_hit(1'b1);
        cyc(20);
        check("held_single", n_valid, 3);
        at_off(5050); set_hit(1'b0);
        at_off(5050); set_hit(1'b1);
        cyc(8);
        check("rearm_valid", n_valid, 4);
        check("dead_gap_ok", (last_cyc - prev_cyc) >= DEAD_CYC, 1);
        at_off(5050); set_hit(1'b0);
        cyc(10);

        // release only seen before the dead counter expires: no retrigger
        v0 = n_valid;
        at_off(PERIOD - 1550); set_hit(1'b1);
        at_off(5050); set_hit(1'b0);
        at_off(5050); set_hit(1'b1);
        cyc(12);
        check("early_release_single", n_valid, v0 + 1);
        at_off(5050); set_hit(1'b0);
        cyc(10);

        // arm dropped in DEAD: back to IDLE, later hits ignored
        v0 = n_valid;
        at_off(PERIOD - 3050); set_hit(1'b1);
        cyc(3);
        at_off(6050); arm = 1'b0;
        at_off(5050); set_hit(1'b0);
        cyc(8);
        at_off(PERIOD - 2050); set_hit(1'b1);
        cyc(3);
        at_off(5050); set_hit(1'b0);
        cyc(6);
        #3000;
        check("armdrop_count", n_valid, v0 + 1);
        check("armdrop_armed", armed, 0);

        // reset one cycle after capture: the pending timestamp is dropped
        at_off(6050); arm = 1'b1;
        cyc(4);
        v0 = n_valid;
        at_off(PERIOD - 1550); set_hit(1'b1);
        @(posedge clk);
        at_off(6050); rst_n = 1'b0;
        #(PERIOD - 6050 + 1000);
        check("rst_no_valid", n_valid, v0);
        check("rst_fine_zero", ts_fine, 0);
        at_off(5050); rst_n = 1'b1;
        cyc(6);
        at_off(5050); set_hit(1'b0);
        cyc(10);

        // randomized traffic: toggles, sub-period pulses, arm and reset changes
        for (int n = 0; n < 600; n++) begin
            int off, r, w;
            r = int'($urandom_range(0, 99));
            off = 100 * int'($urandom_range(0, 98)) + 50;
            @(posedge clk);
            #(off);
            if (r < 30) begin
                set_hit(!hit);
            end else if (r < 40 && !hit) begin
                w = 100 * int'($urandom_range(1, (9950 - off) / 100));
                set_hit(1'b1);
                #(w);
                set_hit(1'b0);
            end else if (r < 46) begin
                arm = !arm;
            end else if (r == 99 && off >= 5050) begin
                rst_n = 1'b0;
                at_off(5050);
                rst_n = 1'b1;
            end
        end
        at_off(5050); set_hit(1'b0);
        cyc(12);
        check("queue_drained", expq.size(), 0);
        finish_run();
    end

endmodule
